// File: rtl/pc_sequencer.sv
// Program-counter sequencer: it chooses the next fetch address (sequential, branch,
// jump, jump-register) and handles the boot, flush, halt and misaligned-JR exception paths.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] EXC_PC   = 32'h0000_0080
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  PCOp,
  input  logic [31:0] branch_target,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_addr,
  input  logic        imem_ack,
  input  logic        stall,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic        flush,
  output logic [31:0] epc,
  output logic        addr_err,
  output logic        halted
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    FLUSH  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic        addr_err_q, addr_err_d;

  assign pc_plus4 = pc_q + 32'd4;
  assign pc       = pc_q;
  assign epc      = epc_q;
  assign addr_err = addr_err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      epc_q      <= 32'h0000_0000;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      addr_err_q <= addr_err_d;
    end
  end

  // addr_err is registered, so it is high during the FLUSH cycle that follows a bad JR
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    addr_err_d = 1'b0;
    case (state_q)
      BOOT:   state_d = FETCH;
      FETCH: begin
        if (imem_ack && !stall) begin
          if (halt) begin
            state_d = HALTED;
          end else begin
            case (PCOp)
              3'b001: begin
                pc_d    = branch_target;
                state_d = FLUSH;
              end
              3'b010: begin
                pc_d    = {pc_plus4[31:28], jump_index, 2'b00};
                state_d = FLUSH;
              end
              3'b100: begin
                state_d = FLUSH;
                if (jr_addr[1:0] == 2'b00) begin
                  pc_d = jr_addr;
                end else begin
                  epc_d      = pc_q;
                  pc_d       = EXC_PC;
                  addr_err_d = 1'b1;
                end
              end
              default: pc_d = pc_plus4;
            endcase
          end
        end else begin
          state_d = FETCH;
        end
      end
      FLUSH:   state_d = FETCH;
      HALTED:  state_d = HALTED;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    flush    = 1'b0;
    halted   = 1'b0;
    case (state_q)
      BOOT:    imem_req = 1'b0;
      FETCH:   imem_req = 1'b1;
      FLUSH:   flush    = 1'b1;
      HALTED:  halted   = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a behavioural next-PC model is checked on every
// falling edge, and hand-computed literal values pin the model at key points.
module tb_pc_sequencer;

  logic        clock;
  logic        reset;
  logic [2:0]  PCOp;
  logic [31:0] branch_target;
  logic [25:0] jump_index;
  logic [31:0] jr_addr;
  logic        imem_ack;
  logic        stall;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic        flush;
  logic [31:0] epc;
  logic        addr_err;
  logic        halted;

  pc_sequencer dut (
    .clock(clock), .reset(reset), .PCOp(PCOp), .branch_target(branch_target),
    .jump_index(jump_index), .jr_addr(jr_addr), .imem_ack(imem_ack), .stall(stall),
    .halt(halt), .pc(pc), .pc_plus4(pc_plus4), .imem_req(imem_req), .flush(flush),
    .epc(epc), .addr_err(addr_err), .halted(halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: mode 0 = just out of reset, 1 = fetching, 2 = squashing, 3 = stopped
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic        m_aerr;

  int checks = 0;
  int errors = 0;
  logic chk_on = 1'b0;

  logic        lit_en = 1'b0;
  logic [31:0] lit_pc, lit_p4, lit_epc;
  logic        lit_req, lit_fl, lit_ae, lit_hl;

  task automatic model_reset();
    m_mode = 0;
    m_pc   = 32'h0000_0000;
    m_epc  = 32'h0000_0000;
    m_aerr = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] nxt;
    nxt    = m_pc + 32'd4;
    m_aerr = 1'b0;
    if (reset) begin
      model_reset();
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 2) begin
      m_mode = 1;
    end else if (m_mode == 1 && imem_ack && !stall) begin
      if (halt) begin
        m_mode = 3;
      end else if (PCOp == 3'd1) begin
        m_pc = branch_target; m_mode = 2;
      end else if (PCOp == 3'd2) begin
        m_pc = {nxt[31:28], jump_index, 2'b00}; m_mode = 2;
      end else if (PCOp == 3'd4) begin
        m_mode = 2;
        if (jr_addr % 4 == 0) m_pc = jr_addr;
        else begin m_epc = m_pc; m_pc = 32'h0000_0080; m_aerr = 1'b1; end
      end else begin
        m_pc = nxt;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: model every cycle, literals when armed
  always @(negedge clock) begin
    if (chk_on) begin
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("epc", epc, m_epc);
      chk("imem_req", {31'd0, imem_req}, {31'd0, m_mode == 1});
      chk("flush", {31'd0, flush}, {31'd0, m_mode == 2});
      chk("halted", {31'd0, halted}, {31'd0, m_mode == 3});
      chk("addr_err", {31'd0, addr_err}, {31'd0, m_aerr});
    end
    if (lit_en) begin
      chk("lit_pc", pc, lit_pc);
      chk("lit_pc_plus4", pc_plus4, lit_p4);
      chk("lit_epc", epc, lit_epc);
      chk("lit_flags", {28'd0, imem_req, flush, addr_err, halted},
          {28'd0, lit_req, lit_fl, lit_ae, lit_hl});
    end
  end

  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic lit(input logic [31:0] p, input logic [31:0] p4, input logic [31:0] e,
                     input logic rq, input logic fl, input logic ae, input logic hl);
    lit_pc = p; lit_p4 = p4; lit_epc = e;
    lit_req = rq; lit_fl = fl; lit_ae = ae; lit_hl = hl;
    lit_en = 1'b1;
    @(negedge clock);
    #1;
    lit_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; PCOp = 3'd0; branch_target = 32'd0; jump_index = 26'd0;
    jr_addr = 32'd0; imem_ack = 1'b0; stall = 1'b0; halt = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk_on = 1'b1;
    lit(32'h0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    cyc();
    lit(32'h0, 32'h4, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // sequential, then stall hold
    imem_ack = 1'b1;
    cyc(); cyc();
    lit(32'h8, 32'hC, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    stall = 1'b1;
    cyc(); lit(32'h8, 32'hC, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(); lit(32'h8, 32'hC, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    stall = 1'b0;
    cyc(); lit(32'hC, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    imem_ack = 1'b0;
    cyc(); lit(32'hC, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    imem_ack = 1'b1;

    // branch then jump
    PCOp = 3'd1; branch_target = 32'h1000_0010;
    cyc(); lit(32'h1000_0010, 32'h1000_0014, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    PCOp = 3'd0;
    cyc(); lit(32'h1000_0010, 32'h1000_0014, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    PCOp = 3'd2; jump_index = 26'h0000040;
    cyc(); lit(32'h1000_0100, 32'h1000_0104, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    PCOp = 3'd0;
    cyc(); lit(32'h1000_0100, 32'h1000_0104, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // misaligned and aligned jump-register
    PCOp = 3'd1; branch_target = 32'h20;
    cyc(); PCOp = 3'd0; cyc();
    PCOp = 3'd4; jr_addr = 32'h0000_0402;
    cyc(); lit(32'h80, 32'h84, 32'h20, 1'b0, 1'b1, 1'b1, 1'b0);
    PCOp = 3'd0;
    cyc(); lit(32'h80, 32'h84, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0);
    PCOp = 3'd4; jr_addr = 32'h0000_0200;
    cyc(); lit(32'h200, 32'h204, 32'h20, 1'b0, 1'b1, 1'b0, 1'b0);
    PCOp = 3'd0; cyc();

    // reserved encodings act sequential; unaligned branch is not checked
    PCOp = 3'd3;
    cyc(); lit(32'h204, 32'h208, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0);
    PCOp = 3'd7; cyc();
    PCOp = 3'd1; branch_target = 32'h33;
    cyc(); PCOp = 3'd0; cyc();
    lit(32'h33, 32'h37, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0);

    // wrap
    PCOp = 3'd1; branch_target = 32'hFFFF_FFFC;
    cyc(); PCOp = 3'd0; cyc();
    lit(32'hFFFF_FFFC, 32'h0, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(); lit(32'h0, 32'h4, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0);

    // reset during FLUSH discards the redirect
    PCOp = 3'd1; branch_target = 32'h500;
    cyc();
    reset = 1'b1; model_reset();
    lit(32'h0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0; PCOp = 3'd0;
    cyc(); lit(32'h0, 32'h4, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();

    // halt ignores PCOp and later inputs, reset leaves it
    halt = 1'b1; PCOp = 3'd2; jump_index = 26'h3FF_FFFF;
    cyc(); lit(32'h4, 32'h8, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    halt = 1'b0; PCOp = 3'd4; jr_addr = 32'h3;
    cyc(); cyc(); lit(32'h4, 32'h8, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    reset = 1'b1; model_reset();
    lit(32'h0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0; PCOp = 3'd0;
    cyc(); cyc();
    lit(32'h4, 32'h8, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
